// File: rtl/cpu_ctrl_if.sv
// Control-unit <-> fetch/datapath signal bundle for cpu_ctrl_fsm.
// master = the control unit, slave = fetch stage / datapath side.
interface cpu_ctrl_if #(
  parameter int IW = 32
);
  logic [IW-1:0] Inst_code;
  logic [IW-1:0] rs_data;
  logic          ZF;
  logic          PC_en;
  logic [1:0]    PC_s;
  logic [IW-1:0] in_1;
  logic [IW-1:0] in_2;
  logic [25:0]   in_3;
  logic [IW-1:0] IR_out;
  logic [2:0]    ALU_OP;
  logic          rt_imm_s;
  logic          imm_s;
  logic [1:0]    w_r_s;
  logic [1:0]    wr_data_s;
  logic          Write_Reg;
  logic          Mem_Write;
  logic          illegal;

  modport master (
    input  Inst_code, rs_data, ZF,
    output PC_en, PC_s, in_1, in_2, in_3, IR_out, ALU_OP, rt_imm_s, imm_s,
           w_r_s, wr_data_s, Write_Reg, Mem_Write, illegal
  );

  modport slave (
    output Inst_code, rs_data, ZF,
    input  PC_en, PC_s, in_1, in_2, in_3, IR_out, ALU_OP, rt_imm_s, imm_s,
           w_r_s, wr_data_s, Write_Reg, Mem_Write, illegal
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit (IF/ID/EX/MEM/WB) driving fetch and datapath selects.
// Define CTRL_ILLEGAL_TRAP_EN to halt on unknown instructions; otherwise they execute as NOPs.
module cpu_ctrl_fsm #(
  parameter int IW   = 32,
  parameter int LINK = 31
) (
  input  logic      clk,
  input  logic      rst,
  cpu_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  if (LINK < 0 || LINK > 31 || IW < 26) begin : g_param_range
    $error("cpu_ctrl_fsm: LINK must be a 5-bit register index and IW >= 26");
  end

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_ir;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [2:0] w_alu_op;
  logic       w_alu_ok;
  logic       w_is_j, w_is_jal, w_is_jr, w_is_br, w_is_bne, w_is_lw, w_is_sw;
  logic       w_legal, w_writes, w_imm_s, w_rt_imm_s, w_taken;

  assign w_op    = r_ir[31:26];
  assign w_funct = r_ir[5:0];

  // ALU-bearing instructions: R-type ALU functs plus every I-type that reaches EX
  always_comb begin
    w_alu_op = '0;
    w_alu_ok = 1'b0;
    if (w_op == 6'h00) begin
      w_alu_ok = 1'b1;
      case (w_funct)
        6'h24:   w_alu_op = 3'b000;
        6'h25:   w_alu_op = 3'b001;
        6'h26:   w_alu_op = 3'b010;
        6'h27:   w_alu_op = 3'b011;
        6'h20:   w_alu_op = 3'b100;
        6'h22:   w_alu_op = 3'b101;
        6'h2A:   w_alu_op = 3'b110;
        6'h04:   w_alu_op = 3'b111;
        default: w_alu_ok = 1'b0;
      endcase
    end else begin
      w_alu_ok = 1'b1;
      case (w_op)
        6'h0C:               w_alu_op = 3'b000;
        6'h0D:               w_alu_op = 3'b001;
        6'h0E:               w_alu_op = 3'b010;
        6'h08, 6'h23, 6'h2B: w_alu_op = 3'b100;
        6'h04, 6'h05:        w_alu_op = 3'b101;
        6'h0A:               w_alu_op = 3'b110;
        default:             w_alu_ok = 1'b0;
      endcase
    end
  end

  assign w_is_j     = (w_op == 6'h02);
  assign w_is_jal   = (w_op == 6'h03);
  assign w_is_jr    = (w_op == 6'h00) && (w_funct == 6'h08);
  assign w_is_br    = (w_op == 6'h04) || (w_op == 6'h05);
  assign w_is_bne   = (w_op == 6'h05);
  assign w_is_lw    = (w_op == 6'h23);
  assign w_is_sw    = (w_op == 6'h2B);
  assign w_legal    = w_alu_ok || w_is_j || w_is_jal || w_is_jr;
  assign w_writes   = w_alu_ok && !w_is_sw && !w_is_br;
  assign w_imm_s    = (w_op == 6'h08) || (w_op == 6'h0A) || w_is_lw || w_is_sw;
  assign w_rt_imm_s = (w_op != 6'h00) && !w_is_br;
  assign w_taken    = bus.ZF ^ w_is_bne;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IF;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IF) r_ir <= bus.Inst_code;
    end
  end

  // All strobes/selects are forced low while reset is held, even though the state is IF
  always_comb begin
    w_next        = r_state;
    bus.PC_en     = 1'b0;
    bus.PC_s      = 2'b00;
    bus.ALU_OP    = '0;
    bus.rt_imm_s  = 1'b0;
    bus.imm_s     = 1'b0;
    bus.w_r_s     = 2'b00;
    bus.wr_data_s = 2'b00;
    bus.Write_Reg = 1'b0;
    bus.Mem_Write = 1'b0;
    if (rst) begin
      case (r_state)
        S_IF: begin
          bus.PC_en = 1'b1;
          w_next    = S_ID;
        end
        S_ID: begin
          w_next = S_IF;
          if (w_is_j) begin
            bus.PC_en = 1'b1;
            bus.PC_s  = 2'b11;
          end else if (w_is_jal) begin
            bus.PC_en     = 1'b1;
            bus.PC_s      = 2'b11;
            bus.Write_Reg = 1'b1;
            bus.w_r_s     = 2'b10;
            bus.wr_data_s = 2'b10;
          end else if (w_is_jr) begin
            bus.PC_en = 1'b1;
            bus.PC_s  = 2'b01;
          end else if (w_legal) begin
            w_next = S_EX;
          end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            w_next = S_HALT;
`else
            w_next = S_IF;
`endif
          end
        end
        S_EX, S_MEM, S_WB: begin
          bus.ALU_OP   = w_alu_op;
          bus.rt_imm_s = w_rt_imm_s;
          bus.imm_s    = w_imm_s;
          if (w_writes) begin
            bus.w_r_s     = (w_op == 6'h00) ? 2'b00 : 2'b01;
            bus.wr_data_s = w_is_lw ? 2'b01 : 2'b00;
          end
          if (r_state == S_EX) begin
            if (w_is_br) begin
              bus.PC_en = w_taken;
              bus.PC_s  = w_taken ? 2'b10 : 2'b00;
              w_next    = S_IF;
            end else if (w_is_lw || w_is_sw) begin
              w_next = S_MEM;
            end else begin
              w_next = S_WB;
            end
          end else if (r_state == S_MEM) begin
            bus.Mem_Write = w_is_sw;
            w_next        = w_is_sw ? S_IF : S_WB;
          end else begin
            bus.Write_Reg = 1'b1;
            w_next        = S_IF;
          end
        end
        S_HALT:  w_next = S_HALT;
        default: w_next = S_IF;
      endcase
    end
  end

  assign bus.in_1   = rst ? bus.rs_data : '0;
  assign bus.in_2   = rst ? ({{(IW-16){r_ir[15]}}, r_ir[15:0]} - IW'(1)) : '0;
  assign bus.in_3   = r_ir[25:0];
  assign bus.IR_out = r_ir;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal = (r_state == S_HALT);
`else
  assign bus.illegal = 1'b0;
`endif

endmodule
